// File: rtl/debug_probe_ctrl_if.sv
// Byte-wide command and response links between the UART side and debug_probe_ctrl.
// The controller uses the slave modport; the UART bridge (or a bench) uses master.
interface debug_probe_ctrl_if;
   logic       cmd_valid;
   logic [7:0] cmd_code;
   logic       cmd_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;

   modport master (
      output cmd_valid, cmd_code, tx_ready,
      input  cmd_ready, tx_valid, tx_data
   );

   modport slave (
      input  cmd_valid, cmd_code, tx_ready,
      output cmd_ready, tx_valid, tx_data
   );
endinterface

// File: rtl/debug_probe_ctrl.sv
// Command-driven debug controller: probe snapshot readout, single-step/run/halt via step_en.
// Optional step cycle counter (codes 0x30 read, 0x31 clear) enabled by DBG_CYCLE_COUNTER_EN.
module debug_probe_ctrl #(
   parameter int NUM_PROBES = 32,
   parameter int PROBE_W    = 32,
   parameter int CNT_W      = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   debug_probe_ctrl_if.slave             bus,
   input  logic [NUM_PROBES*PROBE_W-1:0] probes,
   output logic                          step_en,
   output logic                          running
);

`ifdef DBG_CYCLE_COUNTER_EN
   localparam int SHIFT_W = (CNT_W > PROBE_W) ? CNT_W : PROBE_W;
`else
   localparam int SHIFT_W = PROBE_W;
`endif
   localparam int NB_RAW = $clog2(SHIFT_W / 8 + 1);
   localparam int NB_W   = (NB_RAW < 3) ? 3 : NB_RAW;

   localparam logic [NB_W-1:0] ONE_NB   = NB_W'(1);
   localparam logic [NB_W-1:0] PROBE_NB = NB_W'(PROBE_W / 8);
   localparam logic [5:0] C_STEP = 6'h3F;
   localparam logic [5:0] C_PING = 6'h38;
   localparam logic [5:0] C_RUN  = 6'h39;
   localparam logic [5:0] C_HALT = 6'h3A;
`ifdef DBG_CYCLE_COUNTER_EN
   localparam logic [NB_W-1:0] CNT_NB  = NB_W'(CNT_W / 8);
   localparam logic [5:0] C_CNT_RD  = 6'h30;
   localparam logic [5:0] C_CNT_CLR = 6'h31;
`endif

   if (NUM_PROBES < 1 || NUM_PROBES > 48 || PROBE_W < 8 || PROBE_W > 32 ||
       (PROBE_W % 8) != 0 || CNT_W < 8 || (CNT_W % 8) != 0) begin : g_param_err
      $error("debug_probe_ctrl: illegal parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_STEP, S_SEND} state_e;

   state_e              state_q, state_d;
   logic                running_q, running_d;
   logic [SHIFT_W-1:0]  shift_q, shift_d;
   logic [NB_W-1:0]     nbytes_q, nbytes_d;
`ifdef DBG_CYCLE_COUNTER_EN
   logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

   logic [PROBE_W-1:0]  probe_arr [NUM_PROBES];
   logic [PROBE_W-1:0]  probe_sel;
   logic [5:0]          cmd_idx;
   logic [NB_W-1:0]     size_nb;
   logic                accept;
   logic                tx_take;

   function automatic logic [NB_W-1:0] nb_min(input logic [NB_W-1:0] a,
                                              input logic [NB_W-1:0] b);
      return (a > b) ? b : a;
   endfunction

   for (genvar gi = 0; gi < NUM_PROBES; gi++) begin : g_probe
      assign probe_arr[gi] = probes[gi*PROBE_W +: PROBE_W];
   end

   assign cmd_idx = bus.cmd_code[5:0];
   assign size_nb = NB_W'(bus.cmd_code[7:6]) + ONE_NB;
   assign accept  = bus.cmd_valid & bus.cmd_ready;
   assign tx_take = bus.tx_valid & bus.tx_ready;

   // Indices without a probe fall through the loop and read as zero.
   always_comb begin
      probe_sel = '0;
      for (int i = 0; i < NUM_PROBES; i++) begin
         if (cmd_idx == 6'(i)) probe_sel = probe_arr[i];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         running_q <= 1'b0;
         shift_q   <= '0;
         nbytes_q  <= '0;
`ifdef DBG_CYCLE_COUNTER_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         shift_q   <= shift_d;
         nbytes_q  <= nbytes_d;
`ifdef DBG_CYCLE_COUNTER_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      running_d = running_q;
      shift_d   = shift_q;
      nbytes_d  = nbytes_q;
`ifdef DBG_CYCLE_COUNTER_EN
      cnt_d     = step_en ? cnt_q + CNT_W'(1) : cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d  = S_SEND;
               nbytes_d = ONE_NB;
               shift_d  = '0;
               if (cmd_idx[5:4] == 2'b11) begin
                  case (cmd_idx)
                     C_STEP: begin
                        // A free-running pipeline needs no extra pulse; ack at once.
                        if (running_q) shift_d = SHIFT_W'(8'hFF);
                        else begin
                           state_d = S_STEP;
                           shift_d = shift_q;
                        end
                     end
                     C_PING: shift_d = SHIFT_W'(8'h55);
                     C_RUN: begin
                        running_d = 1'b1;
                        shift_d   = SHIFT_W'(8'h01);
                     end
                     C_HALT: running_d = 1'b0;
`ifdef DBG_CYCLE_COUNTER_EN
                     C_CNT_RD: begin
                        shift_d  = SHIFT_W'(cnt_q);
                        nbytes_d = nb_min(size_nb, CNT_NB);
                     end
                     C_CNT_CLR: cnt_d = '0;
`endif
                     default: ;
                  endcase
               end else begin
                  shift_d  = SHIFT_W'(probe_sel);
                  nbytes_d = nb_min(size_nb, PROBE_NB);
               end
            end
         end
         S_STEP: begin
            state_d  = S_SEND;
            shift_d  = SHIFT_W'(8'hFF);
            nbytes_d = ONE_NB;
         end
         S_SEND: begin
            if (tx_take) begin
               shift_d  = shift_q >> 8;
               nbytes_d = nbytes_q - ONE_NB;
               if (nbytes_q == ONE_NB) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = (state_q == S_IDLE);
      bus.tx_valid  = (state_q == S_SEND);
      bus.tx_data   = shift_q[7:0];
      step_en       = running_q | (state_q == S_STEP);
      running       = running_q;
   end

endmodule

// File: tb/tb_debug_probe_ctrl.sv
// Randomized self-checking bench for debug_probe_ctrl against a command-level byte model.
// Counter checks are compiled in when DBG_CYCLE_COUNTER_EN is defined.
module tb_debug_probe_ctrl;
   localparam int NP = 32;
   localparam int PW = 32;
   localparam int CW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic step_en, running;
   logic [PW-1:0]    probe_v [NP];
   logic [NP*PW-1:0] probes_flat;

   debug_probe_ctrl_if bus ();

   debug_probe_ctrl #(.NUM_PROBES(NP), .PROBE_W(PW), .CNT_W(CW)) dut (
      .clock   (clk),
      .reset   (rst_n),
      .bus     (bus),
      .probes  (probes_flat),
      .step_en (step_en),
      .running (running)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NP; i++) probes_flat[i*PW +: PW] = probe_v[i];
   end

   int total = 0;
   int bad = 0;

   // model state
   bit           exp_run = 1'b0;
   bit           exp_pulse = 1'b0;
   logic [CW-1:0] exp_cnt = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      if (exp_run || exp_pulse) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_tick();
      check_val("idle_tx_valid", bus.tx_valid, 0);
      check_val("idle_cmd_ready", bus.cmd_ready, 1);
      check_val("idle_step_en", step_en, exp_run);
      tick();
   endtask

   task automatic do_cmd(input logic [7:0] code, input bit always_rdy);
      logic [7:0]  exp_q [$];
      logic [63:0] val;
      logic [5:0]  idx;
      int          n, ii, stalls;
      bit          step_wait, r;
      idx = code[5:0];
      ii = int'(idx);
      n = 1;
      val = '0;
      step_wait = 1'b0;
      if (ii < 'h30) begin
         val = (ii < NP) ? 64'(probe_v[ii]) : 64'd0;
         n = int'(code[7:6]) + 1;
         if (n > PW / 8) n = PW / 8;
      end else begin
         case (ii)
            'h3F: begin val = 64'hFF; step_wait = !exp_run; end
            'h38: val = 64'h55;
            'h39: val = 64'h01;
`ifdef DBG_CYCLE_COUNTER_EN
            'h30: begin
               val = 64'(exp_cnt);
               n = int'(code[7:6]) + 1;
               if (n > CW / 8) n = CW / 8;
            end
`endif
            default: val = 64'h00;
         endcase
      end
      for (int k = 0; k < n; k++) exp_q.push_back(val[8*k +: 8]);

      check_val("cmd_ready_pre", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_code  = code;
      tick();
      bus.cmd_valid = 1'b0;
      if (ii == 'h39) exp_run = 1'b1;
      if (ii == 'h3A) exp_run = 1'b0;
`ifdef DBG_CYCLE_COUNTER_EN
      if (ii == 'h31) exp_cnt = '0;
`endif
      if (step_wait) begin
         check_val("step_pulse", step_en, 1);
         check_val("step_tx_early", bus.tx_valid, 0);
         exp_pulse = 1'b1;
         tick();
         exp_pulse = 1'b0;
      end
      check_val("running", running, exp_run);
      foreach (exp_q[b]) begin
         stalls = 0;
         while (1) begin
            check_val("tx_valid", bus.tx_valid, 1);
            check_val($sformatf("tx_data[%0d] code=%02h", b, code), bus.tx_data, exp_q[b]);
            check_val("send_step_en", step_en, exp_run);
            r = always_rdy || (stalls >= 3) || ($urandom_range(0, 1) == 1);
            bus.tx_ready = r;
            tick();
            bus.tx_ready = 1'b0;
            if (r) break;
            stalls++;
         end
      end
      check_val("tx_valid_drop", bus.tx_valid, 0);
      check_val("cmd_ready_post", bus.cmd_ready, 1);
      $display("cmd %02h bytes=%0d val=%0h run=%0d", code, n, val, exp_run);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_run = 1'b0;
      exp_pulse = 1'b0;
      exp_cnt = '0;
      #1;
      check_val("rst_tx_valid", bus.tx_valid, 0);
      check_val("rst_tx_data", bus.tx_data, 0);
      check_val("rst_step_en", step_en, 0);
      check_val("rst_running", running, 0);
      check_val("rst_cmd_ready", bus.cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] code;
      int sel;
      bus.cmd_valid = 1'b0;
      bus.cmd_code  = 8'h00;
      bus.tx_ready  = 1'b0;
      for (int i = 0; i < NP; i++) probe_v[i] = $urandom;

      // reset with a command pending: it must be ignored
      bus.cmd_valid = 1'b1;
      bus.cmd_code  = 8'h38;
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_hold_tx_valid", bus.tx_valid, 0);
      bus.cmd_valid = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      $display("reset released");

      do_cmd(8'h38, 1'b0);
      probe_v[1] = 32'hDEADBEEF;
      do_cmd(8'hC1, 1'b1);
      do_cmd(8'h41, 1'b0);
      do_cmd(8'h3F, 1'b0);
      idle_tick();

      do_cmd(8'h39, 1'b1);
      repeat (10) idle_tick();
      do_cmd(8'h3A, 1'b1);
      idle_tick();
      do_cmd(8'hC0, 1'b1);
      do_cmd(8'h31, 1'b1);
      do_cmd(8'hC0, 1'b0);

      // step while running gives no extra pulse
      do_cmd(8'h39, 1'b0);
      do_cmd(8'h3F, 1'b0);
      do_cmd(8'hC5, 1'b0);
      do_cmd(8'h3A, 1'b0);

      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < NP; i++) probe_v[i] = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            5: code = 8'h38;
            6: code = 8'h3F;
            7: code = 8'h39;
            8: code = 8'h3A;
            9: code = {2'($urandom_range(0, 3)), 6'($urandom_range('h30, 'h3E))};
            default: code = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 'h2F))};
         endcase
         do_cmd(code, 1'b0);
         repeat ($urandom_range(0, 2)) idle_tick();
      end
      do_cmd(8'hC0, 1'b1);

      // reset in the middle of a 4-byte read while running
      do_cmd(8'h39, 1'b1);
      probe_v[2] = 32'h12345678;
      bus.cmd_valid = 1'b1;
      bus.cmd_code  = 8'hC2;
      tick();
      bus.cmd_valid = 1'b0;
      check_val("mid_tx_valid", bus.tx_valid, 1);
      check_val("mid_tx_data0", bus.tx_data, 8'h78);
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      check_val("mid_tx_data1", bus.tx_data, 8'h56);
      #2;
      do_reset();
      #2 rst_n = 1'b1;
      tick();
      idle_tick();
      do_cmd(8'h38, 1'b0);
      do_cmd(8'hC0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
